tv_sync_gen: RTL and testbench

// - PAL/NTSC raster timing generator for the composite video path; sits directly upstream of the chroma generator.
// - Produces the line sync that drives the chroma burst, the colour-enable window, blanking and composite sync.
// - Also provides raster counters for the pixel fetch logic.

---
 rtl/tv_sync_gen_pkg.sv | 33 +++
 rtl/tv_sync_gen_if.sv | 33 +++
 rtl/tv_sync_gen_line_counter.sv | 85 ++++++++
 rtl/tv_sync_gen.sv | 106 ++++++++++
 tb/tb_tv_sync_gen.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/tv_sync_gen_pkg.sv
// Shared timing constants and types for the PAL/NTSC raster generator.
// Contents:
//   - default PAL/NTSC line and frame totals (used as module parameter defaults)
//   - sync, blanking and porch widths, counter width
//   - standard-select enum and the half-line helper
package tv_timing_pkg;

  localparam int CNT_W = 9;
  typedef logic [CNT_W-1:0] cnt_t;

  // Default totals; the modules expose these as overridable parameters.
  localparam int H_TOTAL_PAL_DEF  = 448;
  localparam int H_TOTAL_NTSC_DEF = 444;
  localparam int V_TOTAL_PAL_DEF  = 312;
  localparam int V_TOTAL_NTSC_DEF = 262;

  // Widths are in pixel ticks (horizontal) or lines (vertical).
  localparam cnt_t H_SYNC_W      = 9'd33;
  localparam cnt_t H_BLANK_W     = 9'd84;
  localparam cnt_t H_FRONT_W     = 9'd10;
  localparam cnt_t V_SYNC_LINES  = 9'd3;
  localparam cnt_t V_BLANK_LINES = 9'd16;

  typedef enum logic {
    STD_PAL  = 1'b0,
    STD_NTSC = 1'b1
  } std_e;

  function automatic cnt_t half_line(input cnt_t h_total);
    return h_total >> 1;
  endfunction

endpackage

// File: rtl/tv_sync_gen_if.sv
// Bus between the raster generator and its consumers.
// Signals:
//   sg_ce, sg_pnsel                      : tick enable and standard request (into generator)
//   sg_hsync, sg_csync, sg_blank,
//   sg_cenable, sg_frame                 : sync/blank outputs
//   sg_hcnt, sg_vcnt, sg_pnsel_q         : raster position and active standard
// Modports: master drives sg_ce/sg_pnsel, slave (the generator) drives the rest.
interface tv_sync_gen_if;

  logic                sg_ce;
  logic                sg_pnsel;
  logic                sg_hsync;
  logic                sg_csync;
  logic                sg_blank;
  logic                sg_cenable;
  tv_timing_pkg::cnt_t sg_hcnt;
  tv_timing_pkg::cnt_t sg_vcnt;
  logic                sg_pnsel_q;
  logic                sg_frame;

  modport master (
    output sg_ce, sg_pnsel,
    input  sg_hsync, sg_csync, sg_blank, sg_cenable,
    input  sg_hcnt, sg_vcnt, sg_pnsel_q, sg_frame
  );

  modport slave (
    input  sg_ce, sg_pnsel,
    output sg_hsync, sg_csync, sg_blank, sg_cenable,
    output sg_hcnt, sg_vcnt, sg_pnsel_q, sg_frame
  );

endinterface

// File: rtl/tv_sync_gen_line_counter.sv
// Horizontal/vertical raster counter pair with tick enable and a standard
// select that is only allowed to change on the frame wrap tick.
// Ports:
//   clk_i, rst_i         : clock, asynchronous active-high reset
//   ce_i                 : pixel tick enable
//   pnsel_i              : requested standard (0 PAL, 1 NTSC)
//   hcnt_o, vcnt_o       : current (registered) counters
//   pnsel_o              : standard currently in effect
//   hcnt_next_o, vcnt_next_o, pnsel_next_o : next-state values, for zero-skew decode
//   frame_wrap_o         : next state is the first tick of a frame
module tv_line_counter import tv_timing_pkg::*; #(
  parameter int H_TOTAL_PAL  = H_TOTAL_PAL_DEF,
  parameter int H_TOTAL_NTSC = H_TOTAL_NTSC_DEF,
  parameter int V_TOTAL_PAL  = V_TOTAL_PAL_DEF,
  parameter int V_TOTAL_NTSC = V_TOTAL_NTSC_DEF
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic ce_i,
  input  logic pnsel_i,
  output cnt_t hcnt_o,
  output cnt_t vcnt_o,
  output logic pnsel_o,
  output cnt_t hcnt_next_o,
  output cnt_t vcnt_next_o,
  output logic pnsel_next_o,
  output logic frame_wrap_o
);

  localparam cnt_t H_LAST_PAL  = cnt_t'(H_TOTAL_PAL - 1);
  localparam cnt_t H_LAST_NTSC = cnt_t'(H_TOTAL_NTSC - 1);
  localparam cnt_t V_LAST_PAL  = cnt_t'(V_TOTAL_PAL - 1);
  localparam cnt_t V_LAST_NTSC = cnt_t'(V_TOTAL_NTSC - 1);

  cnt_t hcnt_q, hcnt_d;
  cnt_t vcnt_q, vcnt_d;
  logic pnsel_q, pnsel_d;
  logic wrap;
  cnt_t h_last, v_last;

  always_comb begin
    h_last  = pnsel_q ? H_LAST_NTSC : H_LAST_PAL;
    v_last  = pnsel_q ? V_LAST_NTSC : V_LAST_PAL;
    hcnt_d  = hcnt_q;
    vcnt_d  = vcnt_q;
    pnsel_d = pnsel_q;
    wrap    = 1'b0;
    if (ce_i) begin
      // >= rather than == so a counter left beyond a smaller total wraps at once.
      if (hcnt_q >= h_last) begin
        hcnt_d = '0;
        if (vcnt_q >= v_last) begin
          vcnt_d  = '0;
          pnsel_d = pnsel_i;
          wrap    = 1'b1;
        end else begin
          vcnt_d = vcnt_q + 1'b1;
        end
      end else begin
        hcnt_d = hcnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hcnt_q  <= '0;
      vcnt_q  <= '0;
      pnsel_q <= 1'b0;
    end else begin
      hcnt_q  <= hcnt_d;
      vcnt_q  <= vcnt_d;
      pnsel_q <= pnsel_d;
    end
  end

  assign hcnt_o       = hcnt_q;
  assign vcnt_o       = vcnt_q;
  assign pnsel_o      = pnsel_q;
  assign hcnt_next_o  = hcnt_d;
  assign vcnt_next_o  = vcnt_d;
  assign pnsel_next_o = pnsel_d;
  assign frame_wrap_o = wrap;

endmodule

// File: rtl/tv_sync_gen.sv
// PAL/NTSC raster timing generator: line sync, composite sync (with broad
// pulses), blanking, colour enable, raster counters and frame strobe.
// Ports:
//   sg_clock, sg_reset : clock, asynchronous active-high reset
//   sg_bus (slave)     : sg_ce/sg_pnsel in; sync, blank, counters, frame out
// Build option: define SG_EQUALIZE_EN to put equalising pulses on the three
// lines either side of the broad-pulse lines; otherwise they carry line sync.
// The sync/blank outputs are decoded from the counter next state and
// registered, so they line up with the sg_hcnt/sg_vcnt shown in that cycle.
module tv_sync_gen import tv_timing_pkg::*; #(
  parameter int H_TOTAL_PAL  = H_TOTAL_PAL_DEF,
  parameter int H_TOTAL_NTSC = H_TOTAL_NTSC_DEF,
  parameter int V_TOTAL_PAL  = V_TOTAL_PAL_DEF,
  parameter int V_TOTAL_NTSC = V_TOTAL_NTSC_DEF
) (
  input  logic         sg_clock,
  input  logic         sg_reset,
  tv_sync_gen_if.slave sg_bus
);

  cnt_t hcnt_cur, vcnt_cur, hcnt_next, vcnt_next;
  logic pnsel_cur, pnsel_next, frame_wrap;
  std_e std_next;

  tv_line_counter #(
    .H_TOTAL_PAL  (H_TOTAL_PAL),
    .H_TOTAL_NTSC (H_TOTAL_NTSC),
    .V_TOTAL_PAL  (V_TOTAL_PAL),
    .V_TOTAL_NTSC (V_TOTAL_NTSC)
  ) u_line_counter (
    .clk_i        (sg_clock),
    .rst_i        (sg_reset),
    .ce_i         (sg_bus.sg_ce),
    .pnsel_i      (sg_bus.sg_pnsel),
    .hcnt_o       (hcnt_cur),
    .vcnt_o       (vcnt_cur),
    .pnsel_o      (pnsel_cur),
    .hcnt_next_o  (hcnt_next),
    .vcnt_next_o  (vcnt_next),
    .pnsel_next_o (pnsel_next),
    .frame_wrap_o (frame_wrap)
  );

  // Decode against the standard that will be in effect alongside the new counters.
  assign std_next = std_e'(pnsel_next);

  cnt_t h_total, half, hh;
  logic broad_line, eq_line;
  logic hsync_d, csync_d, blank_d;
`ifdef SG_EQUALIZE_EN
  cnt_t v_total;
`endif

  always_comb begin
    h_total    = (std_next == STD_NTSC) ? cnt_t'(H_TOTAL_NTSC) : cnt_t'(H_TOTAL_PAL);
    half       = half_line(h_total);
    // Position within the current half line; hcnt never reaches 2*HALF.
    hh         = (hcnt_next >= half) ? hcnt_next - half : hcnt_next;
    hsync_d    = !(hcnt_next < H_SYNC_W);
    blank_d    = (hcnt_next < H_BLANK_W) || (hcnt_next >= h_total - H_FRONT_W) ||
                 (vcnt_next < V_BLANK_LINES);
    broad_line = vcnt_next < V_SYNC_LINES;
    eq_line    = 1'b0;
`ifdef SG_EQUALIZE_EN
    v_total    = (std_next == STD_NTSC) ? cnt_t'(V_TOTAL_NTSC) : cnt_t'(V_TOTAL_PAL);
    eq_line    = (vcnt_next >= v_total - 9'd3) ||
                 ((vcnt_next >= V_SYNC_LINES) && (vcnt_next < V_SYNC_LINES + 9'd3));
`endif
    if (broad_line) begin
      csync_d = !(hh < half - H_SYNC_W);
    end else if (eq_line) begin
      csync_d = !(hh < (H_SYNC_W >> 1));
    end else begin
      csync_d = hsync_d;
    end
  end

  logic hsync_q, csync_q, blank_q, frame_q;

  always_ff @(posedge sg_clock or posedge sg_reset) begin
    if (sg_reset) begin
      hsync_q <= 1'b1;
      csync_q <= 1'b1;
      blank_q <= 1'b1;
      frame_q <= 1'b0;
    end else begin
      // The frame strobe is a single-clock pulse even when ticks are sparse.
      frame_q <= frame_wrap;
      if (sg_bus.sg_ce) begin
        hsync_q <= hsync_d;
        csync_q <= csync_d;
        blank_q <= blank_d;
      end
    end
  end

  assign sg_bus.sg_hsync   = hsync_q;
  assign sg_bus.sg_csync   = csync_q;
  assign sg_bus.sg_blank   = blank_q;
  assign sg_bus.sg_cenable = ~blank_q;
  assign sg_bus.sg_frame   = frame_q;
  assign sg_bus.sg_hcnt    = hcnt_cur;
  assign sg_bus.sg_vcnt    = vcnt_cur;
  assign sg_bus.sg_pnsel_q = pnsel_cur;

endmodule

// File: tb/tb_tv_sync_gen.sv
// Bench for tv_sync_gen. A full-size instance covers the line decodes and
// reset behaviour; a second instance with short frames (20 PAL / 18 NTSC
// lines) covers vertical wrap, frame strobe and standard switching.
module tb_tv_sync_gen;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  int   frame_seen = 0;

  always #5 clk = ~clk;

  tv_sync_gen_if bus();
  tv_sync_gen_if bus_s();

  tv_sync_gen u_dut (
    .sg_clock (clk),
    .sg_reset (rst),
    .sg_bus   (bus)
  );

  tv_sync_gen #(
    .V_TOTAL_PAL  (20),
    .V_TOTAL_NTSC (18)
  ) u_short (
    .sg_clock (clk),
    .sg_reset (rst),
    .sg_bus   (bus_s)
  );

  always @(negedge clk) begin
    if (bus_s.sg_frame === 1'b1) frame_seen <= frame_seen + 1;
  end

  // One tick, ce high for a single clock (ticks back to back give ce every 2nd clock).
  task automatic tick();
    @(negedge clk);
    bus.sg_ce = 1'b1; bus_s.sg_ce = 1'b1;
    @(negedge clk);
    bus.sg_ce = 1'b0; bus_s.sg_ce = 1'b0;
  endtask

  // n ticks with ce held high every clock.
  task automatic run_fast(input int n);
    @(negedge clk);
    bus.sg_ce = 1'b1; bus_s.sg_ce = 1'b1;
    repeat (n) @(negedge clk);
    bus.sg_ce = 1'b0; bus_s.sg_ce = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.sg_ce = 1'b0; bus_s.sg_ce = 1'b0;
    bus.sg_pnsel = 1'b0; bus_s.sg_pnsel = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (bus.sg_hcnt !== 9'd0) begin errors++; $display("FAIL reset_hcnt: got %0d want 0", bus.sg_hcnt); end
    checks++; if (bus.sg_vcnt !== 9'd0) begin errors++; $display("FAIL reset_vcnt: got %0d want 0", bus.sg_vcnt); end
    checks++; if (bus.sg_hsync !== 1'b1) begin errors++; $display("FAIL reset_hsync: got %b want 1", bus.sg_hsync); end
    checks++; if (bus.sg_csync !== 1'b1) begin errors++; $display("FAIL reset_csync: got %b want 1", bus.sg_csync); end
    checks++; if (bus.sg_blank !== 1'b1) begin errors++; $display("FAIL reset_blank: got %b want 1", bus.sg_blank); end
    checks++; if (bus.sg_cenable !== 1'b0) begin errors++; $display("FAIL reset_cenable: got %b want 0", bus.sg_cenable); end
    checks++; if (bus.sg_frame !== 1'b0) begin errors++; $display("FAIL reset_frame: got %b want 0", bus.sg_frame); end
    checks++; if (bus.sg_pnsel_q !== 1'b0) begin errors++; $display("FAIL reset_pnsel_q: got %b want 0", bus.sg_pnsel_q); end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (bus.sg_hcnt !== 9'd0) begin errors++; $display("FAIL ce_low_hold_hcnt: got %0d want 0", bus.sg_hcnt); end
    checks++; if (bus.sg_hsync !== 1'b1) begin errors++; $display("FAIL ce_low_hold_hsync: got %b want 1", bus.sg_hsync); end
    $display("test_reset done: checks=%0d errors=%0d", checks, errors);
  endtask

  // Line 0 (broad pulses) walked tick by tick, then the 447->0 wrap.
  task automatic test_broad_line_hwrap();
    logic exp_cs, exp_hs;
    for (int k = 1; k <= 447; k++) begin
      tick();
      exp_hs = !(k <= 32);
      exp_cs = !((k <= 190) || (k >= 224 && k <= 414));
      checks++; if (bus.sg_hcnt !== 9'(k) || bus.sg_vcnt !== 9'd0) begin errors++; $display("FAIL l0_pos: got %0d,%0d want %0d,0", bus.sg_hcnt, bus.sg_vcnt, k); end
      checks++; if (bus.sg_hsync !== exp_hs) begin errors++; $display("FAIL l0_hsync h=%0d: got %b want %b", k, bus.sg_hsync, exp_hs); end
      checks++; if (bus.sg_csync !== exp_cs) begin errors++; $display("FAIL l0_csync h=%0d: got %b want %b", k, bus.sg_csync, exp_cs); end
      checks++; if (bus.sg_blank !== 1'b1) begin errors++; $display("FAIL l0_blank h=%0d: got %b want 1", k, bus.sg_blank); end
      if (k == 100) begin
        @(negedge clk);
        checks++; if (bus.sg_hcnt !== 9'd100) begin errors++; $display("FAIL ce_low_mid_hold: got %0d want 100", bus.sg_hcnt); end
      end
    end
    tick();
    checks++; if (bus.sg_hcnt !== 9'd0 || bus.sg_vcnt !== 9'd1) begin errors++; $display("FAIL hwrap: got %0d,%0d want 0,1", bus.sg_hcnt, bus.sg_vcnt); end
    checks++; if (bus.sg_csync !== 1'b0) begin errors++; $display("FAIL l1_csync_h0: got %b want 0", bus.sg_csync); end
    $display("test_broad_line_hwrap done: checks=%0d errors=%0d", checks, errors);
  endtask

  // Line 3: equalising pulses when enabled, plain line sync otherwise.
  task automatic test_line3();
    logic exp_cs;
    run_fast(895);
    for (int h = 0; h <= 447; h++) begin
      tick();
`ifdef SG_EQUALIZE_EN
      exp_cs = !((h <= 15) || (h >= 224 && h <= 239));
`else
      exp_cs = !(h <= 32);
`endif
      checks++; if (bus.sg_hcnt !== 9'(h) || bus.sg_vcnt !== 9'd3) begin errors++; $display("FAIL l3_pos: got %0d,%0d want %0d,3", bus.sg_hcnt, bus.sg_vcnt, h); end
      checks++; if (bus.sg_csync !== exp_cs) begin errors++; $display("FAIL l3_csync h=%0d: got %b want %b", h, bus.sg_csync, exp_cs); end
      checks++; if (bus.sg_hsync !== !(h <= 32)) begin errors++; $display("FAIL l3_hsync h=%0d: got %b", h, bus.sg_hsync); end
    end
    $display("test_line3 done: checks=%0d errors=%0d", checks, errors);
  endtask

  // Active line 20: sync, blank, colour enable windows.
  task automatic test_line20();
    logic exp_hs, exp_bl;
    run_fast(7168);
    for (int h = 0; h <= 447; h++) begin
      tick();
      exp_hs = !(h <= 32);
      exp_bl = (h <= 83) || (h >= 438);
      checks++; if (bus.sg_hcnt !== 9'(h) || bus.sg_vcnt !== 9'd20) begin errors++; $display("FAIL l20_pos: got %0d,%0d want %0d,20", bus.sg_hcnt, bus.sg_vcnt, h); end
      checks++; if (bus.sg_hsync !== exp_hs) begin errors++; $display("FAIL l20_hsync h=%0d: got %b want %b", h, bus.sg_hsync, exp_hs); end
      checks++; if (bus.sg_csync !== exp_hs) begin errors++; $display("FAIL l20_csync h=%0d: got %b want %b", h, bus.sg_csync, exp_hs); end
      checks++; if (bus.sg_blank !== exp_bl) begin errors++; $display("FAIL l20_blank h=%0d: got %b want %b", h, bus.sg_blank, exp_bl); end
      checks++; if (bus.sg_cenable !== !exp_bl) begin errors++; $display("FAIL l20_cenable h=%0d: got %b want %b", h, bus.sg_cenable, !exp_bl); end
    end
    tick();
    checks++; if (bus.sg_hcnt !== 9'd0 || bus.sg_vcnt !== 9'd21) begin errors++; $display("FAIL l21_start: got %0d,%0d want 0,21", bus.sg_hcnt, bus.sg_vcnt); end
    $display("test_line20 done: checks=%0d errors=%0d", checks, errors);
  endtask

  // Reset asserted at hcnt=10, vcnt=1 clears everything without a clock edge.
  task automatic test_reset_midline();
    @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk); rst = 1'b0;
    run_fast(458);
    checks++; if (bus.sg_hcnt !== 9'd10 || bus.sg_vcnt !== 9'd1) begin errors++; $display("FAIL mid_pos: got %0d,%0d want 10,1", bus.sg_hcnt, bus.sg_vcnt); end
    checks++; if (bus.sg_hsync !== 1'b0 || bus.sg_csync !== 1'b0) begin errors++; $display("FAIL mid_sync: got hs=%b cs=%b want 0,0", bus.sg_hsync, bus.sg_csync); end
    #2 rst = 1'b1;
    #1;
    checks++; if (bus.sg_hcnt !== 9'd0 || bus.sg_vcnt !== 9'd0) begin errors++; $display("FAIL async_rst_cnt: got %0d,%0d want 0,0", bus.sg_hcnt, bus.sg_vcnt); end
    checks++; if (bus.sg_hsync !== 1'b1) begin errors++; $display("FAIL async_rst_hsync: got %b want 1", bus.sg_hsync); end
    checks++; if (bus.sg_csync !== 1'b1) begin errors++; $display("FAIL async_rst_csync: got %b want 1", bus.sg_csync); end
    checks++; if (bus.sg_blank !== 1'b1 || bus.sg_cenable !== 1'b0) begin errors++; $display("FAIL async_rst_blank: got %b/%b want 1/0", bus.sg_blank, bus.sg_cenable); end
    @(negedge clk); rst = 1'b0;
    tick();
    checks++; if (bus.sg_hcnt !== 9'd1 || bus.sg_vcnt !== 9'd0) begin errors++; $display("FAIL restart_pos: got %0d,%0d want 1,0", bus.sg_hcnt, bus.sg_vcnt); end
    checks++; if (bus.sg_hsync !== 1'b0) begin errors++; $display("FAIL restart_hsync: got %b want 0", bus.sg_hsync); end
    $display("test_reset_midline done: checks=%0d errors=%0d", checks, errors);
  endtask

  // Short-frame instance: vertical wrap and single-clock frame strobe.
  task automatic test_vwrap_frame();
    int n0;
    run_fast(8958);
    checks++; if (bus_s.sg_hcnt !== 9'd447 || bus_s.sg_vcnt !== 9'd19) begin errors++; $display("FAIL vlast_pos: got %0d,%0d want 447,19", bus_s.sg_hcnt, bus_s.sg_vcnt); end
    checks++; if (bus_s.sg_frame !== 1'b0) begin errors++; $display("FAIL vlast_frame: got %b want 0", bus_s.sg_frame); end
    tick();
    checks++; if (bus_s.sg_hcnt !== 9'd0 || bus_s.sg_vcnt !== 9'd0) begin errors++; $display("FAIL vwrap_pos: got %0d,%0d want 0,0", bus_s.sg_hcnt, bus_s.sg_vcnt); end
    checks++; if (bus_s.sg_frame !== 1'b1) begin errors++; $display("FAIL vwrap_frame: got %b want 1", bus_s.sg_frame); end
    @(negedge clk);
    checks++; if (bus_s.sg_frame !== 1'b0) begin errors++; $display("FAIL frame_one_clk: got %b want 0", bus_s.sg_frame); end
    n0 = frame_seen;
    run_fast(8960);
    #1;
    checks++; if (frame_seen - n0 !== 1) begin errors++; $display("FAIL frames_per_frame: got %0d want 1", frame_seen - n0); end
    checks++; if (bus_s.sg_frame !== 1'b1 || bus_s.sg_hcnt !== 9'd0 || bus_s.sg_vcnt !== 9'd0) begin errors++; $display("FAIL frame2: got f=%b %0d,%0d want 1 0,0", bus_s.sg_frame, bus_s.sg_hcnt, bus_s.sg_vcnt); end
    $display("test_vwrap_frame done: checks=%0d errors=%0d", checks, errors);
  endtask

  // Request NTSC mid-frame: PAL totals hold until the frame wrap.
  task automatic test_std_switch();
    run_fast(4480);
    bus_s.sg_pnsel = 1'b1;
    checks++; if (bus_s.sg_vcnt !== 9'd10 || bus_s.sg_pnsel_q !== 1'b0) begin errors++; $display("FAIL sw_req: got v=%0d pq=%b want 10,0", bus_s.sg_vcnt, bus_s.sg_pnsel_q); end
    run_fast(4479);
    checks++; if (bus_s.sg_hcnt !== 9'd447 || bus_s.sg_vcnt !== 9'd19) begin errors++; $display("FAIL sw_pal_hold: got %0d,%0d want 447,19", bus_s.sg_hcnt, bus_s.sg_vcnt); end
    checks++; if (bus_s.sg_pnsel_q !== 1'b0) begin errors++; $display("FAIL sw_pq_early: got %b want 0", bus_s.sg_pnsel_q); end
    tick();
    checks++; if (bus_s.sg_frame !== 1'b1 || bus_s.sg_pnsel_q !== 1'b1) begin errors++; $display("FAIL sw_wrap: got f=%b pq=%b want 1,1", bus_s.sg_frame, bus_s.sg_pnsel_q); end
    run_fast(188);
    checks++; if (bus_s.sg_hcnt !== 9'd188 || bus_s.sg_csync !== 1'b0) begin errors++; $display("FAIL ntsc_broad188: got h=%0d cs=%b want 188,0", bus_s.sg_hcnt, bus_s.sg_csync); end
    tick();
    checks++; if (bus_s.sg_csync !== 1'b1) begin errors++; $display("FAIL ntsc_broad189: got %b want 1", bus_s.sg_csync); end
    run_fast(33);
    checks++; if (bus_s.sg_hcnt !== 9'd222 || bus_s.sg_csync !== 1'b0) begin errors++; $display("FAIL ntsc_broad222: got h=%0d cs=%b want 222,0", bus_s.sg_hcnt, bus_s.sg_csync); end
    run_fast(221);
    checks++; if (bus_s.sg_hcnt !== 9'd443 || bus_s.sg_vcnt !== 9'd0) begin errors++; $display("FAIL ntsc_hlast: got %0d,%0d want 443,0", bus_s.sg_hcnt, bus_s.sg_vcnt); end
    tick();
    checks++; if (bus_s.sg_hcnt !== 9'd0 || bus_s.sg_vcnt !== 9'd1) begin errors++; $display("FAIL ntsc_hwrap: got %0d,%0d want 0,1", bus_s.sg_hcnt, bus_s.sg_vcnt); end
    run_fast(7547);
    checks++; if (bus_s.sg_hcnt !== 9'd443 || bus_s.sg_vcnt !== 9'd17 || bus_s.sg_frame !== 1'b0) begin errors++; $display("FAIL ntsc_vlast: got %0d,%0d f=%b want 443,17 f=0", bus_s.sg_hcnt, bus_s.sg_vcnt, bus_s.sg_frame); end
    tick();
    checks++; if (bus_s.sg_hcnt !== 9'd0 || bus_s.sg_vcnt !== 9'd0 || bus_s.sg_frame !== 1'b1) begin errors++; $display("FAIL ntsc_vwrap: got %0d,%0d f=%b want 0,0 f=1", bus_s.sg_hcnt, bus_s.sg_vcnt, bus_s.sg_frame); end
    checks++; if (bus_s.sg_pnsel_q !== 1'b1) begin errors++; $display("FAIL ntsc_pq: got %b want 1", bus_s.sg_pnsel_q); end
    $display("test_std_switch done: checks=%0d errors=%0d", checks, errors);
  endtask

  initial begin
    test_reset();
    test_broad_line_hwrap();
    test_line3();
    test_line20();
    test_reset_midline();
    test_vwrap_frame();
    test_std_switch();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
